ptp_gearbox: RTL
================

# ptp_gearbox

Parametrised bidirectional width converter between the 8-bit pad-level buses of the Manchester Baby tile and its 32-bit internal word datapath. It has two independent channels, each with valid/ready handshakes and full single-beat-per-cycle throughput. The pack channel assembles BEATS narrow beats into one wide word. The unpack channel splits one wide word into BEATS narrow beats. Beat order within a word is selectable.

## Interface
- NARROW_W, 8, width of one narrow beat
- BEATS, 4, narrow beats per wide word; legal range 2..16; WIDE_W = NARROW_W*BEATS
- MSB_FIRST, 0, 0: the first beat occupies bits [NARROW_W-1:0]; 1: the first beat occupies the top slice
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of both channels
- n_valid_i  in  1  pack input beat valid
- n_data_i  in  NARROW_W  pack input beat
- n_ready_o  out  1  pack input ready
- w_valid_o  out  1  packed word valid
- w_data_o  out  WIDE_W  packed word
- w_ready_i  in  1  packed word accepted downstream
- u_valid_i  in  1  unpack input word valid
- u_data_i  in  WIDE_W  unpack input word
- u_ready_o  out  1  unpack input ready
- b_valid_o  out  1  unpacked beat valid
- b_data_o  out  NARROW_W  unpacked beat
- b_ready_i  in  1  unpacked beat accepted downstream
- pack_cnt_o  out  clog2(BEATS)  beats accumulated in the current partial word

## Operation
- Transfer rule: a transfer occurs on an edge where valid && ready. Producers hold data stable while valid && !ready.
- Pack channel:
  - State: accumulator acc[WIDE_W], counter cnt (0..BEATS-1), output register w_data_o with w_valid_o.
  - An accepted beat is written to slice cnt. With MSB_FIRST=1 it goes to slice BEATS-1-cnt instead. cnt then increments.
  - On acceptance of the beat with cnt==BEATS-1:
    - w_data_o <= the completed word, including the beat arriving in that cycle.
    - w_valid_o <= 1.
    - cnt <= 0.
  - w_valid_o clears on the edge where w_ready_i is high, unless a new word completes in the same cycle. In that case w_valid_o stays 1 and w_data_o loads the new word.
  - n_ready_o = !flush_i && !(cnt==BEATS-1 && w_valid_o && !w_ready_i). Beats 0..BEATS-2 are always accepted. Only the final beat stalls, and only while the previous word is still pending.
- Unpack channel:
  - State: hold register hold[WIDE_W], index idx (0..BEATS-1), busy flag.
  - b_valid_o = busy.
  - b_data_o = slice idx of hold, or slice BEATS-1-idx when MSB_FIRST=1.
  - u_ready_o = !flush_i && (!busy || (idx==BEATS-1 && b_ready_i)).
  - On word acceptance: hold <= u_data_i, idx <= 0, busy <= 1.
  - On a beat transfer with idx<BEATS-1: idx increments.
  - On the last-beat transfer with no new word accepted: busy <= 0, idx <= 0.
- pack_cnt_o = cnt.
- flush_i:
  - Takes effect on the next edge: cnt, idx, busy and w_valid_o clear to 0. acc and hold keep their values; they are don't-care.
  - The partial pack word is discarded, as are any pending packed word and unpacked beats.
  - No transfers are accepted on a flush cycle.
  - Downstream handshakes completing in the flush cycle are still counted as delivered.
- Reset (rst_n low, asynchronous):
  - All state clears: acc, hold, w_data_o, cnt, idx, busy, w_valid_o.
  - Outputs during and after reset: w_valid_o=0, w_data_o=0, b_valid_o=0, b_data_o=0, pack_cnt_o=0, n_ready_o=1 and u_ready_o=1 (when flush_i=0).
  - Reset mid-word discards all in-flight data. No partial word is ever emitted.

## Timing
- Pack latency: w_valid_o rises on the edge that accepts the final beat, so it is visible the cycle after.
- Pack throughput: one beat per cycle sustained, giving one word every BEATS cycles when w_ready_i=1.
- Unpack latency: the first beat is valid the cycle after the word is accepted.
- Unpack throughput: with b_ready_i=1, back-to-back words produce BEATS*k consecutive beats with no bubble, because the next word is accepted on the last-beat cycle.
- The ready outputs are combinational from registered state plus w_ready_i, b_ready_i and flush_i. There are no valid-to-ready combinational paths.
- The two channels are fully independent, and simultaneous activity on both is legal.

## Test plan
- Pack, LSB order: with defaults and w_ready_i=1, drive 0x11,0x22,0x33,0x44 on consecutive cycles. Required: w_data_o=0x44332211 with w_valid_o for exactly one cycle, starting one cycle after the 0x44 beat. pack_cnt_o must step 1,2,3,0.
- Pack, MSB order: rebuild with MSB_FIRST=1 and drive the same beats. Required: w_data_o=0x11223344.
- Pack backpressure: hold w_ready_i=0 and stream 0x11..0x88. Required:
  - n_ready_o drops only while 0x88 is presented.
  - Once w_ready_i is raised, 0x44332211 and then 0x88776655 are delivered, with no loss or duplication.
- Unpack back-to-back: with b_ready_i=1, drive 0xDEADBEEF then 0x01234567. Required: 8 consecutive beats EF,BE,AD,DE,67,45,23,01.
- Unpack stall: deassert b_ready_i after beat 2. Required: b_data_o holds 0xAD and u_ready_o=0 until b_ready_i returns.
- Flush and reset:
  - Flush after 2 pack beats and mid-unpack. Required: cnt=0, b_valid_o=0, and the next 4 beats 0xA0..0xA3 produce 0xA3A2A1A0.
  - Pulse rst_n low asynchronously mid-word. Required: all outputs go immediately to their reset values, and no partial word appears afterwards.

Source files
------------

// File: rtl/ptp_gearbox.sv
// ptp_gearbox: bidirectional narrow/wide width converter.
// Pack channel gathers BEATS narrow beats into one wide word; unpack channel
// splits one wide word into BEATS narrow beats. Both channels use valid/ready
// handshakes, run at one beat per cycle and are fully independent.
// MSB_FIRST selects whether the first beat maps to the lowest or highest slice.
module ptp_gearbox #(
    parameter int NARROW_W  = 8,
    parameter int BEATS     = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int WIDE_W   = NARROW_W * BEATS,
    localparam int CNT_W    = $clog2(BEATS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    // pack channel, narrow side
    input  logic                n_valid_i,
    input  logic [NARROW_W-1:0] n_data_i,
    output logic                n_ready_o,
    // pack channel, wide side
    output logic                w_valid_o,
    output logic [WIDE_W-1:0]   w_data_o,
    input  logic                w_ready_i,
    // unpack channel, wide side
    input  logic                u_valid_i,
    input  logic [WIDE_W-1:0]   u_data_i,
    output logic                u_ready_o,
    // unpack channel, narrow side
    output logic                b_valid_o,
    output logic [NARROW_W-1:0] b_data_o,
    input  logic                b_ready_i,
    // status
    output logic [CNT_W-1:0]    pack_cnt_o
);

    // A wide word viewed as an array of narrow slices; element 0 is the low slice.
    typedef logic [BEATS-1:0][NARROW_W-1:0] word_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);

    // Map a beat position within a word to the slice it occupies.
    function automatic logic [CNT_W-1:0] slot_of(input logic [CNT_W-1:0] pos);
        logic [CNT_W-1:0] slot;
        if (MSB_FIRST) begin
            slot = LAST_IDX - pos;
        end else begin
            slot = pos;
        end
        return slot;
    endfunction

    // ------------------------------------------------------------------
    // Pack channel state
    // ------------------------------------------------------------------
    word_t            acc_q,     acc_d;
    word_t            w_data_q,  w_data_d;
    logic             w_valid_q, w_valid_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic pack_last_s;
    logic n_ready_s;
    logic beat_acc_s;
    logic word_done_s;

    // ------------------------------------------------------------------
    // Unpack channel state
    // ------------------------------------------------------------------
    word_t            hold_q, hold_d;
    logic [CNT_W-1:0] idx_q,  idx_d;
    logic             busy_q, busy_d;

    logic unpack_last_s;
    logic u_ready_s;
    logic word_acc_s;
    logic beat_xfer_s;

    // Pack handshake decode: only the final beat of a word can stall, and only
    // while the previously completed word has not yet been taken downstream.
    always_comb begin
        pack_last_s = (cnt_q == LAST_IDX);
        n_ready_s   = !flush_i && !(pack_last_s && w_valid_q && !w_ready_i);
        beat_acc_s  = n_valid_i && n_ready_s;
        word_done_s = beat_acc_s && pack_last_s;
    end

    // Pack next-state: place the accepted beat into its slice, and hand the
    // completed word (including this cycle's beat) to the output register.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        w_data_d  = w_data_q;
        w_valid_d = w_valid_q;
        if (flush_i) begin
            // Partial and pending words are dropped; acc/w_data keep stale contents.
            cnt_d     = '0;
            w_valid_d = 1'b0;
        end else begin
            if (beat_acc_s) begin
                acc_d[slot_of(cnt_q)] = n_data_i;
                if (pack_last_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE_IDX;
                end
            end else begin
                cnt_d = cnt_q;
            end

            if (word_done_s) begin
                // A new word completing wins over a same-cycle drain.
                w_data_d  = acc_d;
                w_valid_d = 1'b1;
            end else if (w_ready_i) begin
                w_valid_d = 1'b0;
            end else begin
                w_valid_d = w_valid_q;
            end
        end
    end

    // Pack channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            w_data_q  <= '0;
            w_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
        end
    end

    // Unpack handshake decode: a new word is taken when idle, or on the cycle
    // the last beat of the current word leaves, so words stream without bubbles.
    always_comb begin
        unpack_last_s = (idx_q == LAST_IDX);
        u_ready_s     = !flush_i && (!busy_q || (unpack_last_s && b_ready_i));
        word_acc_s    = u_valid_i && u_ready_s;
        beat_xfer_s   = busy_q && b_ready_i;
    end

    // Unpack next-state: load a new word, advance the beat index, or go idle.
    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        if (flush_i) begin
            // A beat handshaking in this cycle still counts as delivered.
            idx_d  = '0;
            busy_d = 1'b0;
        end else if (word_acc_s) begin
            hold_d = u_data_i;
            idx_d  = '0;
            busy_d = 1'b1;
        end else if (beat_xfer_s) begin
            if (unpack_last_s) begin
                idx_d  = '0;
                busy_d = 1'b0;
            end else begin
                idx_d  = idx_q + ONE_IDX;
                busy_d = 1'b1;
            end
        end else begin
            idx_d  = idx_q;
            busy_d = busy_q;
        end
    end

    // Unpack channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
        end
    end

    // Ready outputs depend only on registered state, the downstream readies
    // and flush, never on the incoming valids.
    assign n_ready_o  = n_ready_s;
    assign u_ready_o  = u_ready_s;

    assign w_valid_o  = w_valid_q;
    assign w_data_o   = w_data_q;
    assign pack_cnt_o = cnt_q;

    assign b_valid_o  = busy_q;
    assign b_data_o   = hold_q[slot_of(idx_q)];

endmodule
